// File: rtl/yc_pkg.sv
// Shared types and constants for the Y/C burst sequencer.
package yc_pkg;

  localparam int unsigned PHASE_W_DEF = 40;
  localparam int unsigned LUT_W_DEF   = 8;

  // Subcarrier increments per clk_sys cycle for a 40-bit accumulator.
  localparam logic [39:0] NTSC_INC = 40'd91625968981;
  localparam logic [39:0] PAL_INC  = 40'd114532461227;

  typedef enum logic [1:0] {
    StIdle,
    StWaitSync,
    StDelay,
    StBurst
  } yc_state_e;

endpackage

// File: rtl/yc_phase_acc.sv
// Chroma subcarrier phase accumulator with a frame-latched increment.
// Optional feature: define MISTER_YC_PHASE_RESET_EN to clear the accumulator on
// every frame start, giving identical subcarrier phase each frame.
module yc_phase_acc
  import yc_pkg::*;
#(
  parameter int unsigned PHASE_W = PHASE_W_DEF,
  parameter int unsigned LUT_W   = LUT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               latch_i,        // load phase_inc_i into the active increment
  input  logic               frame_start_i,  // vsync rising edge
  input  logic [PHASE_W-1:0] phase_inc_i,
  output logic [LUT_W-1:0]   chroma_phase_o
);

  logic [PHASE_W-1:0] acc_q, acc_d;
  logic [PHASE_W-1:0] inc_q, inc_d;

  // Next accumulator value (free-running wrap) and increment latch.
  always_comb begin
    acc_d = acc_q + inc_q;
`ifdef MISTER_YC_PHASE_RESET_EN
    if (frame_start_i) begin
      acc_d = '0;
    end
`else
    if (frame_start_i) begin
      acc_d = acc_q + inc_q;
    end
`endif
    inc_d = latch_i ? phase_inc_i : inc_q;
  end

  // Accumulator and increment registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      acc_q <= '0;
      inc_q <= '0;
    end else begin
      acc_q <= acc_d;
      inc_q <= inc_d;
    end
  end

  assign chroma_phase_o = acc_q[PHASE_W-1 -: LUT_W];

endmodule

// File: rtl/yc_burst_sequencer.sv
// Y/C burst sequencer: burst window timing, PAL V-switch and frame-latched
// PAL/increment selection. Optional feature macro: MISTER_YC_PHASE_RESET_EN
// (handled in yc_phase_acc).
module yc_burst_sequencer
  import yc_pkg::*;
#(
  parameter int unsigned PHASE_W     = PHASE_W_DEF,
  parameter int unsigned LUT_W       = LUT_W_DEF,
  parameter int unsigned BURST_START = 26,
  parameter int unsigned BURST_LEN   = 108,
  parameter int unsigned CNT_W       = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               yc_en_i,
  input  logic               pal_i,
  input  logic [PHASE_W-1:0] phase_inc_i,
  input  logic               hsync_i,
  input  logic               vsync_i,
  output logic [LUT_W-1:0]   chroma_phase_o,
  output logic               burst_en_o,
  output logic               pal_vswitch_o,
  output logic               pal_active_o,
  output logic               busy_o
);

  localparam logic [CNT_W-1:0] DelayLast = CNT_W'(BURST_START - 1);
  localparam logic [CNT_W-1:0] BurstLast = CNT_W'(BURST_LEN - 1);

  yc_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hsync_q, vsync_q;
  logic             pal_active_q, pal_active_d;
  logic             pal_vswitch_q, pal_vswitch_d;

  logic hs_fall, hs_rise, vs_rise, latch;

  assign hs_fall = hsync_q & ~hsync_i;
  assign hs_rise = ~hsync_q & hsync_i;
  assign vs_rise = ~vsync_q & vsync_i;
  // Frame values load on vsync rise and when leaving IDLE.
  assign latch   = vs_rise | ((state_q == StIdle) & yc_en_i);

  yc_phase_acc #(
    .PHASE_W (PHASE_W),
    .LUT_W   (LUT_W)
  ) u_acc (
    .clk            (clk),
    .reset          (reset),
    .latch_i        (latch),
    .frame_start_i  (vs_rise),
    .phase_inc_i    (phase_inc_i),
    .chroma_phase_o (chroma_phase_o)
  );

  // Sequencer next state and delay/burst counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (yc_en_i) state_d = StWaitSync;
      end
      StWaitSync: begin
        if (hs_fall && !vsync_i) begin
          state_d = StDelay;
          cnt_d   = '0;
        end
      end
      StDelay: begin
        if (hs_rise || vs_rise) begin
          state_d = StWaitSync;
        end else if (cnt_q == DelayLast) begin
          state_d = StBurst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StBurst: begin
        if (hs_rise || vs_rise || (cnt_q == BurstLast)) begin
          state_d = StWaitSync;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = StIdle;
    endcase
    // Disable wins over every other transition.
    if (state_q != StIdle && !yc_en_i) begin
      state_d = StIdle;
    end
  end

  // PAL flag latch and V-switch; toggle uses the pre-update pal_active.
  always_comb begin
    pal_active_d  = latch ? pal_i : pal_active_q;
    pal_vswitch_d = pal_vswitch_q;
    if (!pal_active_q) begin
      pal_vswitch_d = 1'b0;
    end else if (hs_rise) begin
      pal_vswitch_d = ~pal_vswitch_q;
    end
  end

  // State, counter, edge-detect and PAL registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      pal_active_q  <= 1'b0;
      pal_vswitch_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      hsync_q       <= hsync_i;
      vsync_q       <= vsync_i;
      pal_active_q  <= pal_active_d;
      pal_vswitch_q <= pal_vswitch_d;
    end
  end

  assign burst_en_o    = (state_q == StBurst);
  assign busy_o        = (state_q != StIdle);
  assign pal_vswitch_o = pal_vswitch_q;
  assign pal_active_o  = pal_active_q;

endmodule

// File: tb/tb_yc_burst_sequencer.sv
// Directed bench for yc_burst_sequencer.
module tb_yc_burst_sequencer;
  import yc_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        yc_en;
  logic        pal;
  logic [39:0] phase_inc;
  logic        hsync;
  logic        vsync;
  logic [7:0]  chroma_phase;
  logic        burst_en;
  logic        pal_vswitch;
  logic        pal_active;
  logic        busy;

  int n_total = 0;
  int n_bad   = 0;

  // Reference accumulator: load flags are set by the stimulus that causes them.
  logic [39:0] exp_acc = '0;
  logic [39:0] exp_inc = '0;
  logic        ld_pend = 1'b0;
  logic [39:0] ld_val  = '0;
  logic        vs_pend = 1'b0;

  always #5 clk = ~clk;

  yc_burst_sequencer dut (
    .clk            (clk),
    .reset          (reset),
    .yc_en_i        (yc_en),
    .pal_i          (pal),
    .phase_inc_i    (phase_inc),
    .hsync_i        (hsync),
    .vsync_i        (vsync),
    .chroma_phase_o (chroma_phase),
    .burst_en_o     (burst_en),
    .pal_vswitch_o  (pal_vswitch),
    .pal_active_o   (pal_active),
    .busy_o         (busy)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_total++;
    if (obs !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, want);
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset) begin
      exp_acc = '0;
      exp_inc = '0;
    end else begin
`ifdef MISTER_YC_PHASE_RESET_EN
      if (vs_pend) exp_acc = '0;
      else         exp_acc = exp_acc + exp_inc;
`else
      exp_acc = exp_acc + exp_inc;
`endif
      if (ld_pend) exp_inc = ld_val;
    end
    ld_pend = 1'b0;
    vs_pend = 1'b0;
    #1;
  endtask

  task automatic check_phase(input string tag);
    check_eq(tag, 64'(chroma_phase), 64'(exp_acc[39:32]));
  endtask

  // One-cycle vsync pulse, optionally coincident with an hsync rise.
  task automatic vs_pulse(input logic with_hs);
    vsync = 1'b1;
    if (with_hs) hsync = 1'b1;
    ld_pend = 1'b1;
    ld_val  = phase_inc;
    vs_pend = 1'b1;
    step();
  endtask

  task automatic hs_pulse();
    hsync = 1'b1;
    step();
    step();
    hsync = 1'b0;
    step();
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int highs;
    logic want_b;
    reset = 1'b1; yc_en = 1'b0; pal = 1'b0; phase_inc = '0; hsync = 1'b0; vsync = 1'b0;
    repeat (3) step();
    check_eq("rst_chroma", 64'(chroma_phase), 64'd0);
    check_eq("rst_burst", 64'(burst_en), 64'd0);
    check_eq("rst_vsw", 64'(pal_vswitch), 64'd0);
    check_eq("rst_palact", 64'(pal_active), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);

    // Enable with NTSC increment, loaded on leaving IDLE.
    reset = 1'b0; yc_en = 1'b1; phase_inc = NTSC_INC;
    ld_pend = 1'b1; ld_val = NTSC_INC;
    step();
    check_eq("en_busy", 64'(busy), 64'd1);
    check_eq("en_chroma0", 64'(chroma_phase), 64'd0);
    step();
    check_eq("ntsc_1clk", 64'(chroma_phase), 64'd21);
    repeat (11) step();
    // 12*NTSC_INC = 2^40 - 4, so the index sits just below the wrap.
    check_eq("ntsc_12clk", 64'(chroma_phase), 64'd255);
    check_phase("ntsc_model");

    // Burst latency: hsync high 10 clks then low; cycle n is the first low cycle.
    hsync = 1'b1;
    repeat (10) step();
    hsync = 1'b0;
    highs = 0;
    for (int k = 1; k <= 140; k++) begin
      step();
      want_b = (k >= 27) && (k <= 134);
      if (burst_en) highs++;
      check_eq($sformatf("burst_k%0d", k), 64'(burst_en), 64'(want_b));
    end
    check_eq("burst_len", 64'(highs), 64'd108);
    check_phase("burst_acc");

    // Drop yc_en inside the burst window.
    hsync = 1'b1;
    repeat (3) step();
    hsync = 1'b0;
    repeat (32) step();
    check_eq("burst_mid", 64'(burst_en), 64'd1);
    yc_en = 1'b0;
    step();
    check_eq("dis_burst", 64'(burst_en), 64'd0);
    check_eq("dis_busy", 64'(busy), 64'd0);
    check_phase("dis_acc0");
    repeat (5) step();
    check_phase("dis_acc5");
    yc_en = 1'b1;
    ld_pend = 1'b1; ld_val = NTSC_INC;
    step();
    check_eq("reen_busy", 64'(busy), 64'd1);

    // Mid-frame increment change only takes effect at vsync rise.
    phase_inc = PAL_INC;
    for (int i = 0; i < 4; i++) begin
      step();
      check_phase($sformatf("inc_hold%0d", i));
    end
    vs_pulse(1'b0);
    vsync = 1'b0;
    check_phase("inc_vs");
`ifdef MISTER_YC_PHASE_RESET_EN
    check_eq("inc_vs_zero", 64'(chroma_phase), 64'd0);
`endif
    for (int i = 0; i < 4; i++) begin
      step();
      check_phase($sformatf("inc_pal%0d", i));
    end
    check_eq("palact_ntsc", 64'(pal_active), 64'd0);

    // PAL V-switch alternation.
    pal = 1'b1;
    vs_pulse(1'b0);
    vsync = 1'b0;
    step();
    check_eq("palact_on", 64'(pal_active), 64'd1);
    check_eq("vsw_init", 64'(pal_vswitch), 64'd0);
    for (int i = 0; i < 4; i++) begin
      hsync = 1'b1;
      step();
      check_eq($sformatf("vsw_%0d", i), 64'(pal_vswitch), 64'((i % 2) == 0));
      step();
      hsync = 1'b0;
      step();
      step();
    end
    pal = 1'b0;
    hs_pulse();
    check_eq("vsw_midframe", 64'(pal_vswitch), 64'd1);
    check_eq("palact_hold", 64'(pal_active), 64'd1);
    vs_pulse(1'b0);
    vsync = 1'b0;
    step();
    check_eq("palact_off", 64'(pal_active), 64'd0);
    check_eq("vsw_cleared", 64'(pal_vswitch), 64'd0);
    hs_pulse();
    check_eq("vsw_held0", 64'(pal_vswitch), 64'd0);
    check_phase("pal_acc");

    // Coincident vsync and hsync rise: toggle uses the old pal_active.
    pal = 1'b1;
    vs_pulse(1'b0);
    vsync = 1'b0;
    repeat (2) step();
    pal = 1'b0;
    vs_pulse(1'b1);
    check_eq("sim_vsw", 64'(pal_vswitch), 64'd1);
    check_eq("sim_palact", 64'(pal_active), 64'd0);
    vsync = 1'b0; hsync = 1'b0;
    step();
    check_eq("sim_vsw_next", 64'(pal_vswitch), 64'd0);

    // Accumulator wrap: reach 2^40-1, then step by 2.
    reset = 1'b1; yc_en = 1'b0;
    repeat (2) step();
    check_eq("rst2_chroma", 64'(chroma_phase), 64'd0);
    reset = 1'b0; yc_en = 1'b1; phase_inc = '1;
    ld_pend = 1'b1; ld_val = '1;
    step();
    phase_inc = 40'd2;
    vs_pulse(1'b0);
    vsync = 1'b0;
`ifndef MISTER_YC_PHASE_RESET_EN
    check_eq("wrap_top", 64'(chroma_phase), 64'd255);
`endif
    check_phase("wrap_top_m");
    step();
`ifndef MISTER_YC_PHASE_RESET_EN
    check_eq("wrap_zero", 64'(chroma_phase), 64'd0);
`endif
    check_phase("wrap_zero_m");
    step();
    check_phase("wrap_after");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
